pilot_plant: RTL and testbench

Closed-loop environment model for the `pilot` flight/sequence controller benchmark. It samples the controller's command vector (y1–y22) and drives the controller's status vector (x1–x27), so locked and unlocked controller builds can run autonomously in simulation and on FPGA. It also flags protocol violations and counts s15-loop iterations, making premature loop exits visible.

---
 rtl/pilot_plant.sv | 139 +++++++++++++
 tb/tb_pilot_plant.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pilot_plant.sv
// rtl/pilot_plant.sv - closed-loop plant model for the pilot controller benchmark.
// Samples the y command vector on posedge and returns a registered x status vector.
module pilot_plant #(
  parameter int START_DLY = 4,
  parameter int IDLE_GAP  = 3,
  parameter int MOVE_LAT  = 5,
  parameter int DWELL     = 6,
  parameter int LOOP_N    = 8,
  parameter int POS_MAX   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] y_cmd,
  input  logic [27:0] cfg_x,
  input  logic        abort,
  output logic [27:0] x_sts,
  output logic [7:0]  loop_cnt,
  output logic        err
);

  typedef enum logic [1:0] {ST_WAIT, ST_REQ, ST_GAP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'((START_DLY < 1 ? 1 : START_DLY) - 1);
  localparam logic [15:0] GAP_LAST  = 16'((IDLE_GAP < 1 ? 1 : IDLE_GAP) - 1);
  localparam logic [7:0]  MOVE_SAT  = 8'(MOVE_LAT);
  localparam logic [7:0]  DWELL_V   = 8'(DWELL);
  localparam logic [8:0]  LOOP_LIM  = 9'(LOOP_N);
  localparam logic [2:0]  POS_SAT   = 3'(POS_MAX);
  // status bits that are passed straight through from cfg_x
  localparam logic [27:0] CFG_MASK  = 28'hF71F1BC;

  state_t      state, state_nxt;
  logic [15:0] seq_cnt, seq_cnt_nxt;
  logic [7:0]  mv_cnt, mv_nxt;
  logic [7:0]  dw_cnt, dw_nxt;
  logic [2:0]  pos, pos_nxt;
  logic [7:0]  loop_nxt;
  logic        y22_d;
  logic [27:0] sts_nxt;
  logic        ack, viol;

  logic unused_bits;
  assign unused_bits = ^{y_cmd[0], y_cmd[3], y_cmd[19:9]};

  assign ack  = y_cmd[7] & y_cmd[8];
  assign viol = (y_cmd[1] & y_cmd[2]) | (y_cmd[4] ^ y_cmd[5]) |
                (y_cmd[7] ^ y_cmd[8]) | (y_cmd[21] & y_cmd[22]);

  always_comb begin
    state_nxt   = state;
    seq_cnt_nxt = seq_cnt;
    case (state)
      ST_WAIT: begin
        if (seq_cnt == WAIT_LAST) begin
          state_nxt   = ST_REQ;
          seq_cnt_nxt = '0;
        end else begin
          seq_cnt_nxt = seq_cnt + 16'd1;
        end
      end
      ST_REQ: begin
        if (ack) begin
          state_nxt   = ST_GAP;
          seq_cnt_nxt = '0;
        end
      end
      ST_GAP: begin
        if (seq_cnt == GAP_LAST) begin
          state_nxt   = ST_WAIT;
          seq_cnt_nxt = '0;
        end else begin
          seq_cnt_nxt = seq_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt   = ST_WAIT;
        seq_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    mv_nxt = '0;
    if (y_cmd[6]) mv_nxt = (mv_cnt == MOVE_SAT) ? mv_cnt : mv_cnt + 8'd1;

    // the dwell timer reloads only on a fresh y22 rising edge
    dw_nxt = '0;
    if (y_cmd[22]) begin
      if (!y22_d)            dw_nxt = DWELL_V;
      else if (dw_cnt != '0) dw_nxt = dw_cnt - 8'd1;
    end

    pos_nxt = pos;
    if (ack || y_cmd[20])            pos_nxt = '0;
    else if (y_cmd[2] && !y_cmd[1])  pos_nxt = (pos == POS_SAT) ? pos : pos + 3'd1;
    else if (y_cmd[1] && !y_cmd[2])  pos_nxt = (pos == 3'd0) ? pos : pos - 3'd1;

    loop_nxt = loop_cnt;
    if (ack)                              loop_nxt = '0;
    else if (y_cmd[21] && loop_cnt != 8'hFF) loop_nxt = loop_cnt + 8'd1;
  end

  always_comb begin
    sts_nxt     = cfg_x & CFG_MASK;
    sts_nxt[1]  = (state_nxt == ST_REQ);
    sts_nxt[6]  = (mv_nxt == MOVE_SAT);
    sts_nxt[9]  = ~abort;
    sts_nxt[10] = ({1'b0, loop_nxt} < LOOP_LIM);
    sts_nxt[11] = (dw_nxt != '0);
    sts_nxt[17] = pos_nxt[2];
    sts_nxt[18] = pos_nxt[1];
    sts_nxt[19] = pos_nxt[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_WAIT;
      seq_cnt  <= '0;
      mv_cnt   <= '0;
      dw_cnt   <= '0;
      pos      <= '0;
      loop_cnt <= '0;
      y22_d    <= 1'b0;
      err      <= 1'b0;
      x_sts    <= '0;
    end else begin
      state    <= state_nxt;
      seq_cnt  <= seq_cnt_nxt;
      mv_cnt   <= mv_nxt;
      dw_cnt   <= dw_nxt;
      pos      <= pos_nxt;
      loop_cnt <= loop_nxt;
      y22_d    <= y_cmd[22];
      err      <= err | viol;
      x_sts    <= sts_nxt;
    end
  end

endmodule

// File: tb/tb_pilot_plant.sv
// tb/tb_pilot_plant.sv - self-checking bench for pilot_plant.
// Directed scenarios plus randomized traffic against a cycle-history reference model.
module tb_pilot_plant;

  localparam int SD = 4, IG = 3, ML = 5, DW = 6, LN = 8, PM = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [22:0] y_cmd = '0;
  logic [27:0] cfg_x = '0;
  logic        abort = 1'b0;
  logic [27:0] x_sts;
  logic [7:0]  loop_cnt;
  logic        err;

  int errors = 0;
  int checks = 0;

  pilot_plant #(.START_DLY(SD), .IDLE_GAP(IG), .MOVE_LAT(ML), .DWELL(DW),
                .LOOP_N(LN), .POS_MAX(PM)) dut (
    .clk(clk), .rst(rst), .y_cmd(y_cmd), .cfg_x(cfg_x), .abort(abort),
    .x_sts(x_sts), .loop_cnt(loop_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: x1 is high once the posedge count reaches ready_at; x6/x11 derive from run lengths.
  int cyc, ready_at, run6, run22, m_pos, m_loop;
  bit m_x1, m_err, m_ab, m_live;
  logic [27:0] m_cfg;
  int pass_bits[18] = '{2, 3, 4, 5, 7, 8, 12, 13, 14, 15, 16, 20, 21, 22, 24, 25, 26, 27};

  function automatic logic [22:0] yb(input int n);
    logic [22:0] one;
    one = 23'd1;
    return one << n;
  endfunction

  function automatic logic [27:0] exp_sts();
    logic [27:0] e;
    e = '0;
    if (!m_live) return e;
    for (int i = 0; i < 18; i++) e[pass_bits[i]] = m_cfg[pass_bits[i]];
    e[1]  = m_x1;
    e[6]  = (run6 >= ML);
    e[9]  = !m_ab;
    e[10] = (m_loop < LN);
    e[11] = (run22 >= 1 && run22 <= DW);
    e[17] = m_pos[2];
    e[18] = m_pos[1];
    e[19] = m_pos[0];
    return e;
  endfunction

  task automatic model_reset();
    cyc = 0; ready_at = SD; run6 = 0; run22 = 0; m_pos = 0; m_loop = 0;
    m_x1 = 0; m_err = 0; m_ab = 0; m_live = 0; m_cfg = '0;
  endtask

  task automatic model_tick(input logic [22:0] y);
    bit ack;
    ack = y[7] && y[8];
    cyc++;
    if (ack && m_x1) ready_at = cyc + IG + SD;
    m_x1  = (cyc >= ready_at);
    run6  = y[6] ? run6 + 1 : 0;
    run22 = y[22] ? run22 + 1 : 0;
    if (ack || y[20])        m_pos = 0;
    else if (y[2] && !y[1])  m_pos = (m_pos + 1 > PM) ? PM : m_pos + 1;
    else if (y[1] && !y[2])  m_pos = (m_pos - 1 < 0) ? 0 : m_pos - 1;
    if (ack)        m_loop = 0;
    else if (y[21]) m_loop = (m_loop + 1 > 255) ? 255 : m_loop + 1;
    if ((y[1] && y[2]) || (y[4] != y[5]) || (y[7] != y[8]) || (y[21] && y[22])) m_err = 1;
    m_ab   = abort;
    m_cfg  = cfg_x;
    m_live = 1;
  endtask

  task automatic step(input logic [22:0] y);
    y_cmd = y;
    @(posedge clk);
    model_tick(y);
    #1;
  endtask

  task automatic do_reset();
    y_cmd = '0;
    rst = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cfg_x = 28'($urandom);
    abort = 1'b0;
    y_cmd = '0;
    rst = 1'b1;
    #2;
    model_reset();
    checks++; if (x_sts !== 28'd0) begin errors++; $display("FAIL reset_x_sts: got %h expected 0", x_sts); end
    checks++; if (loop_cnt !== 8'd0) begin errors++; $display("FAIL reset_loop_cnt: got %0d expected 0", loop_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    @(negedge clk);
    rst = 1'b0;
    step('0);
    checks++; if (x_sts !== exp_sts()) begin errors++; $display("FAIL post_reset_sts: got %h expected %h", x_sts, exp_sts()); end
    checks++; if (x_sts[10:9] !== 2'b11) begin errors++; $display("FAIL post_reset_x10_x9: got %b expected 11", x_sts[10:9]); end
  endtask

  task automatic test_start();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step('0);
      checks++; if (x_sts[1] !== (k >= 4)) begin errors++; $display("FAIL start_x1 k=%0d: got %b expected %b", k, x_sts[1], (k >= 4)); end
    end
  endtask

  task automatic test_ack();
    step(yb(7) | yb(8));
    checks++; if (x_sts[1] !== 1'b0) begin errors++; $display("FAIL ack_x1_drop: got %b expected 0", x_sts[1]); end
    checks++; if (loop_cnt !== 8'd0) begin errors++; $display("FAIL ack_loop_cnt: got %0d expected 0", loop_cnt); end
    for (int k = 1; k <= 8; k++) begin
      step('0);
      checks++; if (x_sts[1] !== (k >= 7)) begin errors++; $display("FAIL ack_x1 k=%0d: got %b expected %b", k, x_sts[1], (k >= 7)); end
    end
  endtask

  task automatic test_motion();
    for (int k = 1; k <= 7; k++) begin
      step(yb(6));
      checks++; if (x_sts[6] !== (k >= 5)) begin errors++; $display("FAIL motion_x6 k=%0d: got %b expected %b", k, x_sts[6], (k >= 5)); end
    end
    step('0);
    checks++; if (x_sts[6] !== 1'b0) begin errors++; $display("FAIL motion_drop: got %b expected 0", x_sts[6]); end
  endtask

  task automatic test_dwell();
    for (int k = 1; k <= 8; k++) begin
      step(yb(22));
      checks++; if (x_sts[11] !== (k <= 6)) begin errors++; $display("FAIL dwell_x11 k=%0d: got %b expected %b", k, x_sts[11], (k <= 6)); end
    end
    step('0);
    checks++; if (x_sts[11] !== 1'b0) begin errors++; $display("FAIL dwell_drop: got %b expected 0", x_sts[11]); end
  endtask

  task automatic test_position();
    logic [2:0] p;
    for (int k = 1; k <= 9; k++) begin
      step(yb(2));
      p = {x_sts[17], x_sts[18], x_sts[19]};
      checks++; if (p !== 3'((k > 7) ? 7 : k)) begin errors++; $display("FAIL pos_up k=%0d: got %0d expected %0d", k, p, (k > 7) ? 7 : k); end
    end
    step(yb(1)); step(yb(1));
    p = {x_sts[17], x_sts[18], x_sts[19]};
    checks++; if (p !== 3'd5) begin errors++; $display("FAIL pos_down: got %0d expected 5", p); end
    step(yb(20));
    p = {x_sts[17], x_sts[18], x_sts[19]};
    checks++; if (p !== 3'd0) begin errors++; $display("FAIL pos_clear: got %0d expected 0", p); end
    step(yb(2)); step(yb(2)); step(yb(20) | yb(2));
    p = {x_sts[17], x_sts[18], x_sts[19]};
    checks++; if (p !== 3'd0) begin errors++; $display("FAIL pos_y20_y2: got %0d expected 0", p); end
    step(yb(2)); step(yb(7) | yb(8) | yb(2));
    p = {x_sts[17], x_sts[18], x_sts[19]};
    checks++; if (p !== 3'd0) begin errors++; $display("FAIL pos_ack_y2: got %0d expected 0", p); end
  endtask

  task automatic test_loop();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(yb(21));
      checks++; if (loop_cnt !== 8'(k)) begin errors++; $display("FAIL loop_cnt k=%0d: got %0d expected %0d", k, loop_cnt, k); end
      checks++; if (x_sts[10] !== (k < 8)) begin errors++; $display("FAIL loop_x10 k=%0d: got %b expected %b", k, x_sts[10], (k < 8)); end
    end
    step(yb(7) | yb(8) | yb(21));
    checks++; if (loop_cnt !== 8'd0 || x_sts[10] !== 1'b1) begin errors++; $display("FAIL loop_ack_wins: got cnt=%0d x10=%b expected cnt=0 x10=1", loop_cnt, x_sts[10]); end
    abort = 1'b1;
    step('0);
    checks++; if (x_sts[9] !== 1'b0) begin errors++; $display("FAIL abort_x9: got %b expected 0", x_sts[9]); end
    abort = 1'b0;
    step('0);
    checks++; if (x_sts[9] !== 1'b1) begin errors++; $display("FAIL abort_release: got %b expected 1", x_sts[9]); end
    for (int k = 0; k < 260; k++) step(yb(21));
    checks++; if (loop_cnt !== 8'd255 || x_sts[10] !== 1'b0) begin errors++; $display("FAIL loop_sat: got cnt=%0d x10=%b expected cnt=255 x10=0", loop_cnt, x_sts[10]); end
  endtask

  task automatic test_protocol();
    logic [22:0] bad[3];
    bad[0] = yb(4);
    bad[1] = yb(8);
    bad[2] = yb(21) | yb(22);
    do_reset();
    step(yb(4) | yb(5));
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_legal: got %b expected 0", err); end
    step(yb(1) | yb(2));
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_y1_y2: got %b expected 1", err); end
    step(yb(7) | yb(8)); step('0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    rst = 1'b1;
    #1;
    checks++; if (err !== 1'b0 || x_sts !== 28'd0 || loop_cnt !== 8'd0) begin errors++; $display("FAIL async_reset: got err=%b x=%h cnt=%0d expected all 0", err, x_sts, loop_cnt); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      step('0);
      step(bad[i]);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pattern %0d: got %b expected 1", i, err); end
    end
  endtask

  task automatic test_random();
    logic [22:0] y;
    for (int seg = 0; seg < 4; seg++) begin
      cfg_x = 28'($urandom);
      do_reset();
      for (int n = 0; n < 150; n++) begin
        y = 23'($urandom) & 23'($urandom);
        y[7]  = ($urandom_range(0, 11) == 0);
        y[8]  = ($urandom_range(0, 15) == 0) ? ~y[7] : y[7];
        y[5]  = ($urandom_range(0, 15) == 0) ? ~y[4] : y[4];
        y[21] = ($urandom_range(0, 1) == 0);
        if (y[21] && $urandom_range(0, 7) != 0) y[22] = 1'b0;
        if (y[1] && y[2] && $urandom_range(0, 7) != 0) y[1] = 1'b0;
        if (seg == 0 && n < 100) begin
          y[8] = y[7]; y[5] = y[4]; y[22] = y[22] & ~y[21]; y[1] = y[1] & ~y[2];
        end
        abort = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 19) == 0) cfg_x = 28'($urandom);
        step(y);
        checks++; if (x_sts !== exp_sts()) begin errors++; $display("FAIL rand_sts seg=%0d n=%0d: got %h expected %h", seg, n, x_sts, exp_sts()); end
        checks++; if (loop_cnt !== 8'(m_loop)) begin errors++; $display("FAIL rand_loop seg=%0d n=%0d: got %0d expected %0d", seg, n, loop_cnt, m_loop); end
        checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err seg=%0d n=%0d: got %b expected %b", seg, n, err, m_err); end
      end
    end
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_ack();
    test_motion();
    test_dwell();
    test_position();
    test_loop();
    test_protocol();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
